line_draw_arbiter: RTL and testbench

LINE_DRAW_ARBITER -- requirements
Module: line_draw_arbiter

---
 rtl/line_draw_arbiter.sv | 156 +++++++++++++++
 tb/tb_line_draw_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/line_draw_arbiter.sv
// ---------------------------------------------------------------------------
// line_draw_arbiter: round-robin arbiter for two line-segment requesters that
// shares one line drawer and forwards its pixels to the framebuffer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module line_draw_arbiter #(
  parameter int TIMEOUT     = 4096,
  parameter int LOAD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [1:0][10:0]    rx0,
  input  logic [1:0][10:0]    ry0,
  input  logic [1:0][10:0]    rx1,
  input  logic [1:0][10:0]    ry1,
  input  logic [1:0]          rcolor,
  output logic [1:0]          ack,
  output logic [1:0]          seg_done,
  output logic                seg_err,
  output logic                drw_start,
  output logic signed [10:0]  drw_x0,
  output logic signed [10:0]  drw_y0,
  output logic signed [10:0]  drw_x1,
  output logic signed [10:0]  drw_y1,
  input  logic                drw_done,
  input  logic signed [10:0]  drw_x,
  input  logic signed [10:0]  drw_y,
  output logic signed [10:0]  pix_x,
  output logic signed [10:0]  pix_y,
  output logic                pix_color,
  output logic                pix_we
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int LC_W = $clog2(LOAD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;

  state_t                state_q;
  logic                  owner_q;
  logic                  last_q;
  logic                  color_q;
  logic [1:0]            ack_q;
  logic [1:0]            seg_done_q;
  logic                  seg_err_q;
  logic                  drw_start_q;
  logic signed [10:0]    drw_x0_q, drw_y0_q, drw_x1_q, drw_y1_q;
  logic signed [10:0]    pix_x_q, pix_y_q;
  logic                  pix_color_q;
  logic                  pix_we_q;
  logic [WD_W-1:0]       wd_q;
  logic [LC_W-1:0]       ld_q;
  logic                  grant_d;

  // A tie goes to the requester that was not granted last.
  always_comb begin
    grant_d = req[1];
    if (req == 2'b11) grant_d = ~last_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      color_q     <= 1'b0;
      ack_q       <= 2'b00;
      seg_done_q  <= 2'b00;
      seg_err_q   <= 1'b0;
      drw_start_q <= 1'b0;
      drw_x0_q    <= '0;
      drw_y0_q    <= '0;
      drw_x1_q    <= '0;
      drw_y1_q    <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= 1'b0;
      pix_we_q    <= 1'b0;
      wd_q        <= '0;
      ld_q        <= '0;
    end else begin
      ack_q      <= 2'b00;
      seg_done_q <= 2'b00;
      pix_we_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          drw_start_q <= 1'b0;
          if (|req) begin
            owner_q  <= grant_d;
            last_q   <= grant_d;
            drw_x0_q <= rx0[grant_d];
            drw_y0_q <= ry0[grant_d];
            drw_x1_q <= rx1[grant_d];
            drw_y1_q <= ry1[grant_d];
            color_q  <= rcolor[grant_d];
            ack_q    <= 2'b01 << grant_d;
            ld_q     <= '0;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          wd_q <= '0;
          if (ld_q == LC_W'(LOAD_CYCLES - 1)) begin
            state_q     <= RUN;
            drw_start_q <= 1'b1;
          end else begin
            ld_q <= ld_q + 1'b1;
          end
        end
        RUN: begin
          pix_x_q     <= drw_x;
          pix_y_q     <= drw_y;
          pix_color_q <= color_q;
          // The write for a RUN cycle lands one cycle later, so it is only
          // issued while staying in RUN; FINISH therefore never writes.
          if (drw_done) begin
            state_q    <= FINISH;
            seg_done_q <= 2'b01 << owner_q;
            seg_err_q  <= 1'b0;
          end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            state_q    <= FINISH;
            seg_done_q <= 2'b01 << owner_q;
            seg_err_q  <= 1'b1;
          end else begin
            pix_we_q <= 1'b1;
            wd_q     <= wd_q + 1'b1;
          end
        end
        FINISH: begin
          state_q     <= IDLE;
          drw_start_q <= 1'b0;
          seg_err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign seg_done  = seg_done_q;
  assign seg_err   = seg_err_q;
  assign drw_start = drw_start_q;
  assign drw_x0    = drw_x0_q;
  assign drw_y0    = drw_y0_q;
  assign drw_x1    = drw_x1_q;
  assign drw_y1    = drw_y1_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign pix_we    = pix_we_q;

endmodule

`default_nettype wire

// File: tb/tb_line_draw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_line_draw_arbiter: transaction-level checks of line_draw_arbiter against
// a drawer model and a round-robin grant model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_line_draw_arbiter;

  localparam int TIMEOUT     = 16;
  localparam int LOAD_CYCLES = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          req;
  logic [1:0][10:0]    rx0, ry0, rx1, ry1;
  logic [1:0]          rcolor;
  logic [1:0]          ack, seg_done;
  logic                seg_err, drw_start, drw_done, pix_color, pix_we;
  logic signed [10:0]  drw_x0, drw_y0, drw_x1, drw_y1;
  logic signed [10:0]  drw_x, drw_y, pix_x, pix_y;

  int vectors     = 0;
  int miscompares = 0;
  int last_grant  = 1;

  line_draw_arbiter #(.TIMEOUT(TIMEOUT), .LOAD_CYCLES(LOAD_CYCLES)) dut (
    .clk(clk), .reset(reset), .req(req),
    .rx0(rx0), .ry0(ry0), .rx1(rx1), .ry1(ry1), .rcolor(rcolor),
    .ack(ack), .seg_done(seg_done), .seg_err(seg_err), .drw_start(drw_start),
    .drw_x0(drw_x0), .drw_y0(drw_y0), .drw_x1(drw_x1), .drw_y1(drw_y1),
    .drw_done(drw_done), .drw_x(drw_x), .drw_y(drw_y),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_we(pix_we)
  );

  always #10 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_requests();
    for (int i = 0; i < 2; i++) begin
      rx0[i] = 11'($urandom); ry0[i] = 11'($urandom);
      rx1[i] = 11'($urandom); ry1[i] = 11'($urandom);
    end
    rcolor = 2'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; drw_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_seg_done", seg_done, 0);
    chk("rst_seg_err", seg_err, 0);
    chk("rst_pix_we", pix_we, 0);
    chk("rst_drw_start", drw_start, 0);
    chk("rst_drw_x0", drw_x0, 0);
    chk("rst_drw_y1", drw_y1, 0);
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_y", pix_y, 0);
    chk("rst_pix_color", pix_color, 0);
    reset = 1'b0;
    last_grant = 1;
    @(negedge clk);
  endtask

  // One request/segment transaction. dlen = pixel cycles before the drawer
  // reports done (-1 = never), abort_at = RUN cycle at which reset is hit.
  task automatic serve(input logic [1:0] reqv,
                       input logic signed [10:0] x0, input logic signed [10:0] y0,
                       input logic signed [10:0] x1, input logic signed [10:0] y1,
                       input logic col, input int dlen, input bit pulse,
                       input int abort_at);
    int own, lowcnt, rc, nwr;
    bit exp_err, done_seen;
    logic signed [10:0] ex[$], ey[$];
    logic signed [10:0] px, py;

    own = (reqv == 2'b11) ? ((last_grant == 0) ? 1 : 0) : (reqv[0] ? 0 : 1);
    scramble_requests();
    rx0[own] = x0; ry0[own] = y0; rx1[own] = x1; ry1[own] = y1;
    rcolor[own] = col;
    req = reqv;
    @(negedge clk);
    chk("ack_owner", ack, 32'd1 << own);
    last_grant = own;
    chk("drw_x0", drw_x0, x0);
    chk("drw_y0", drw_y0, y0);
    chk("drw_x1", drw_x1, x1);
    chk("drw_y1", drw_y1, y1);
    chk("load_start_low", drw_start, 0);
    req = 2'b00;
    scramble_requests();
    drw_done = (dlen == 0);
    lowcnt = 1;
    while (lowcnt < 20) begin
      @(negedge clk);
      if (drw_start) break;
      lowcnt++;
      chk("ack_one_cycle", ack, 0);
    end
    chk("load_len", lowcnt, LOAD_CYCLES);

    exp_err = (dlen < 0) || (dlen >= TIMEOUT);
    rc = 0; nwr = 0; done_seen = 0;
    while (rc < TIMEOUT + 8) begin
      rc++;
      if (pulse) req = (rc == 2) ? 2'b01 : 2'b00;
      px = 11'($urandom); py = 11'($urandom);
      drw_x = px; drw_y = py;
      drw_done = (dlen >= 0) && (rc > dlen);
      if (!drw_done) begin ex.push_back(px); ey.push_back(py); end
      if (rc == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk("abort_drw_start", drw_start, 0);
        chk("abort_pix_we", pix_we, 0);
        chk("abort_seg_done", seg_done, 0);
        chk("abort_ack", ack, 0);
        reset = 1'b0; drw_done = 1'b0;
        last_grant = 1;
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_done", seg_done, 0);
        end
        return;
      end
      @(negedge clk);
      chk("run_ack", ack, 0);
      chk("run_start", drw_start, 1);
      if (pix_we) begin
        nwr++;
        if (ex.size() > 0) begin
          chk("pix_x", pix_x, ex.pop_front());
          chk("pix_y", pix_y, ey.pop_front());
          chk("pix_color", pix_color, col);
        end else begin
          chk("pix_extra_write", pix_we, 0);
        end
      end
      if (seg_done != 2'b00) begin done_seen = 1; break; end
    end
    chk("seg_finished", done_seen, 1);
    chk("seg_done_owner", seg_done, 32'd1 << own);
    chk("seg_err", seg_err, exp_err);
    chk("run_cycles", rc, exp_err ? TIMEOUT : dlen + 1);
    chk("write_count", nwr, exp_err ? TIMEOUT - 1 : dlen);
    chk("finish_pix_we", pix_we, 0);
    chk("finish_x0_stable", drw_x0, x0);
    chk("finish_y1_stable", drw_y1, y1);
    drw_done = 1'b0;
    req = 2'b00;
    @(negedge clk);
    chk("idle_start_low", drw_start, 0);
    chk("idle_no_done", seg_done, 0);
    chk("idle_no_ack", ack, 0);
  endtask

  initial begin
    logic signed [10:0] a, b, c, d;
    logic [1:0] rv;
    int dl;
    req = 2'b00; drw_done = 1'b0; drw_x = '0; drw_y = '0;
    scramble_requests();
    do_reset();

    // Basic single-requester segment.
    serve(2'b01, 11'sd10, 11'sd20, 11'sd30, 11'sd25, 1'b1, 12, 0, 0);

    // Ties alternate starting with requester 0 after reset.
    do_reset();
    for (int i = 0; i < 4; i++)
      serve(2'b11, 11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom),
            1'($urandom), 5, 0, 0);

    // Drawer never finishes: watchdog abort.
    serve(2'b10, 11'sd5, -11'sd7, 11'sd300, 11'sd40, 1'b0, -1, 0, 0);

    // Reset in the middle of requester 1's RUN, then requester 1 again.
    serve(2'b10, 11'sd1, 11'sd2, 11'sd3, 11'sd4, 1'b1, 20, 0, 3);
    serve(2'b10, 11'sd50, 11'sd60, 11'sd70, 11'sd80, 1'b1, 4, 0, 0);

    // A one-cycle req pulse while busy must be ignored.
    serve(2'b10, 11'sd9, 11'sd9, -11'sd9, 11'sd0, 1'b1, 6, 1, 0);

    // Degenerate point with drw_done already high before RUN.
    serve(2'b01, 11'sd100, 11'sd100, 11'sd100, 11'sd100, 1'b1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 20; i++) begin
      rv = 2'($urandom_range(1, 3));
      dl = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 20));
      a = 11'($urandom); b = 11'($urandom); c = 11'($urandom); d = 11'($urandom);
      serve(rv, a, b, c, d, 1'($urandom), dl, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
